// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage sitting between the register file read
// ports and its write port. Single-cycle ALU ops, iterative shift-add multiply,
// and a one-cycle write-enable pulse carrying the result back to the file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module exec_unit #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [DATA_WIDTH-1:0] q_a,
   input  logic [DATA_WIDTH-1:0] q_b,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] data_c,
   output logic [ADDR_WIDTH-1:0] addr_c,
   output logic                  we,
   output logic                  zero,
   output logic                  carry
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] a_r, b_r;
   logic [2:0]            op_r;
   logic [ADDR_WIDTH-1:0] dst_r;
   logic [DATA_WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]         cnt;

   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_cy;
   logic [DATA_WIDTH:0]   sum;
   logic [31:0]           shamt;
   logic [DATA_WIDTH-1:0] mul_sum;

   // Single-cycle ALU on the operands latched at accept; carry is only
   // meaningful for ADD (carry-out) and SUB (borrow).
   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      sum     = {1'b0, a_r} + {1'b0, b_r};
      shamt   = 32'(b_r) % 32'(DATA_WIDTH);
      case (op_r)
         OP_ADD: begin
            alu_res = sum[DATA_WIDTH-1:0];
            alu_cy  = sum[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res = a_r - b_r;
            alu_cy  = (a_r < b_r);
         end
         OP_AND:  alu_res = a_r & b_r;
         OP_OR:   alu_res = a_r | b_r;
         OP_XOR:  alu_res = a_r ^ b_r;
         OP_SHL:  alu_res = a_r << shamt;
         default: alu_res = a_r;  // PASS; MUL never reaches EXEC
      endcase
   end

   // One shift-add step: the accumulate this cycle would produce.
   always_comb begin
      mul_sum = acc + (mplier[0] ? mcand : '0);
   end

   // Control FSM plus registered outputs. busy mirrors "state != IDLE" and
   // we is high only while in WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         we     <= 1'b0;
         data_c <= '0;
         addr_c <= '0;
         zero   <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               we <= 1'b0;
               if (start) begin
                  a_r    <= q_a;
                  b_r    <= q_b;
                  op_r   <= op;
                  dst_r  <= dst;
                  acc    <= '0;
                  mcand  <= q_a;
                  mplier <= q_b;
                  cnt    <= CW'(DATA_WIDTH);
                  busy   <= 1'b1;
                  state  <= (op == OP_MUL) ? MUL : EXEC;
               end
            end
            EXEC: begin
               data_c <= alu_res;
               addr_c <= dst_r;
               zero   <= (alu_res == '0);
               carry  <= alu_cy;
               we     <= 1'b1;
               state  <= WB;
            end
            MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               // Last of exactly DATA_WIDTH steps: publish the final accumulate.
               if (cnt == CW'(1)) begin
                  data_c <= mul_sum;
                  addr_c <= dst_r;
                  zero   <= (mul_sum == '0);
                  carry  <= 1'b0;
                  we     <= 1'b1;
                  state  <= WB;
               end
            end
            WB: begin
               we    <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               we    <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: randomized and directed ops, a reference model that
// computes results with plain arithmetic, and a scoreboard queue drained by
// a monitor whenever the DUT pulses we.
module tb_exec_unit;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int EW = DW + AW + 2;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, MUL = 3'd6, PASS = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] dst = '0;
  logic [DW-1:0] q_a = '0;
  logic [DW-1:0] q_b = '0;
  logic          busy, we, zero, carry;
  logic [DW-1:0] data_c;
  logic [AW-1:0] addr_c;

  exec_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
    .q_a(q_a), .q_b(q_b), .busy(busy), .data_c(data_c), .addr_c(addr_c),
    .we(we), .zero(zero), .carry(carry)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  int rem = 0;        // model: busy cycles left for the op in flight
  int acc_cnt = 0;    // model: number of accepted ops
  int rst_gen = 0;    // model: number of reset edges seen
  bit checking = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {data, addr, zero, carry}
  function automatic logic [EW-1:0] ref_model(input logic [2:0] o, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [AW-1:0] d);
    logic [31:0]   wide;
    logic [DW-1:0] r;
    logic          c;
    c = 1'b0;
    r = '0;
    case (o)
      ADD: begin wide = 32'(a) + 32'(b); r = wide[DW-1:0]; c = wide[DW]; end
      SUB: begin r = a - b; c = (a < b); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      SHL:  r = a << (int'(b) % DW);
      MUL:  begin wide = 32'(a) * 32'(b); r = wide[DW-1:0]; end
      default: r = a;
    endcase
    return {r, d, (r == '0), c};
  endfunction

  // ---------------- reference model (acceptance + expected results) ----------------
  always @(posedge clk) begin
    if (rst) begin
      rem = 0;
      exp_q.delete();
      rst_gen++;
    end else if (rem > 0) begin
      rem--;
    end else if (start) begin
      exp_q.push_back(ref_model(op, q_a, q_b, dst));
      rem = (op == MUL) ? DW + 1 : 2;
      acc_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] held = '0;
  int seen_rst = 0;
  always @(negedge clk) begin
    if (checking) begin
      if (rst_gen != seen_rst) begin
        seen_rst = rst_gen;
        held = '0;
      end
      check("busy", 32'(busy), 32'(rem > 0));
      check("we", 32'(we), 32'(rem == 1));
      if (we === 1'b1 && exp_q.size() > 0) held = exp_q.pop_front();
      check("data_c", 32'(data_c), 32'(held[EW-1 -: DW]));
      check("addr_c", 32'(addr_c), 32'(held[AW+1 -: AW]));
      check("zero", 32'(zero), 32'(held[1]));
      check("carry", 32'(carry), 32'(held[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds start until the model accepts, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] d);
    int n;
    n = acc_cnt;
    start = 1'b1; op = o; q_a = a; q_b = b; dst = d;
    for (int t = 0; t < 100 && acc_cnt == n; t++) @(negedge clk);
    if (acc_cnt == n) check("accept_timeout", 32'(acc_cnt), 32'(n + 1));
    start = 1'b0;
    q_a = DW'($urandom);
    q_b = DW'($urandom);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && rem != 0; t++) @(negedge clk);
    if (rem != 0) check("idle_timeout", 32'(rem), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    checking = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(ADD, 16'd4, 16'd5, 4'd10);          wait_idle();
    issue(ADD, 16'hFFFF, 16'h0001, 4'd1);     wait_idle();
    issue(SUB, 16'd3, 16'd5, 4'd2);           wait_idle();
    issue(SUB, 16'd7, 16'd7, 4'd3);           wait_idle();
    issue(MUL, 16'd7, 16'd6, 4'd4);           wait_idle();
    issue(MUL, 16'h0100, 16'h0100, 4'd5);     wait_idle();
    issue(SHL, 16'h0003, 16'd17, 4'd6);       wait_idle();
    issue(XOR_, 16'hF0F0, 16'hFFFF, 4'd7);    wait_idle();
    issue(PASS, 16'hBEEF, 16'h1234, 4'd15);   wait_idle();
    issue(MUL, 16'hFFFF, 16'hFFFF, 4'd0);     wait_idle();

    // start held high with operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      q_a = DW'($urandom);
      q_b = DW'($urandom);
      dst = AW'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // reset asserted at edge 8 of a multiply, then ADD right after
    issue(MUL, 16'd123, 16'd45, 4'd9);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(ADD, 16'd1, 16'd1, 4'd8);
    wait_idle();

    // randomized back-to-back traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), DW'($urandom), DW'($urandom), AW'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    // ---------------- final report ----------------
    check("drain", 32'(exp_q.size()), 32'd0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
